// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: state encoding, default sizing and state-class helpers shared by
// the CNN layer scheduler and its watchdog.
package cnn_ctrl_pkg;
    localparam int NUM_NEURONS_DEF = 30;
    localparam int TIMEOUT_DEF     = 65535;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        CONV     = 3'd2,
        POOL     = 3'd3,
        NEXT     = 3'd4,
        COMPLETE = 3'd5,
        ERROR    = 3'd6
    } state_e;
    function automatic logic is_busy(state_e s);
        return s inside {LOAD_W, CONV, POOL, NEXT};
    endfunction
    // States that wait on an engine and are therefore guarded by the watchdog
    function automatic logic is_timed(state_e s);
        return s inside {LOAD_W, CONV, POOL};
    endfunction
endpackage

// File: rtl/cnn_layer_scheduler_if.sv
// cnn_layer_scheduler_if: host and layer-engine handshake bundle; the scheduler
// takes the slave side, the host/engines (or a bench) the master side.
interface cnn_layer_scheduler_if #(parameter int IDX_W = 5);
    logic             start_i;
    logic             abort_i;
    logic             busy_o;
    logic             wgt_load_start_o;
    logic             wgt_load_done_i;
    logic             conv_enable_o;
    logic             conv_done_i;
    logic             pool_enable_o;
    logic             pool_done_i;
    logic [IDX_W-1:0] neuron_idx_o;
    logic             cnn_done_o;
    logic             error_o;
    modport slave (
        input  start_i, abort_i, wgt_load_done_i, conv_done_i, pool_done_i,
        output busy_o, wgt_load_start_o, conv_enable_o, pool_enable_o, neuron_idx_o, cnn_done_o, error_o
    );
    modport master (
        output start_i, abort_i, wgt_load_done_i, conv_done_i, pool_done_i,
        input  busy_o, wgt_load_start_o, conv_enable_o, pool_enable_o, neuron_idx_o, cnn_done_o, error_o
    );
endinterface

// File: rtl/cnn_watchdog.sv
// cnn_watchdog: per-state cycle counter; expired_o flags the cycle in which the
// count would reach TIMEOUT_CYCLES-1 with the wait still outstanding.
module cnn_watchdog
    import cnn_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TMO_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + TMO_W'(1) : cnt_q;
    assign expired_o = en_i && (cnt_q == TMO_W'(TIMEOUT_CYCLES - 2));
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler: runs weight-load, conv and pool once per output channel,
// with abort, watchdog timeout and fully registered outputs.
module cnn_layer_scheduler
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS    = NUM_NEURONS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int IDX_W          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic                   clk,
    input logic                   reset,
    cnn_layer_scheduler_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, wls_q, conv_q, pool_q, done_q, err_q;
    logic             expired;
    cnn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_W(TMO_W)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_d != state_q),
        .en_i      (is_timed(state_q)),
        .expired_o (expired)
    );
    // Abort outranks done and timeout; a done in the timeout cycle outranks expiry
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q inside {IDLE, ERROR}) begin
            if (bus.start_i) begin
                state_d = LOAD_W;
                idx_d   = '0;
            end
        end else if (bus.abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LOAD_W:   state_d = bus.wgt_load_done_i ? CONV : expired ? ERROR : LOAD_W;
                CONV:     state_d = bus.conv_done_i     ? POOL : expired ? ERROR : CONV;
                POOL:     state_d = bus.pool_done_i     ? NEXT : expired ? ERROR : POOL;
                NEXT: begin
                    state_d = (idx_q == LAST) ? COMPLETE : LOAD_W;
                    idx_d   = (idx_q == LAST) ? idx_q : idx_q + IDX_W'(1);
                end
                default:  state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            wls_q   <= 1'b0;
            conv_q  <= 1'b0;
            pool_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= is_busy(state_d);
            wls_q   <= (state_d == LOAD_W) && (state_q != LOAD_W);
            conv_q  <= state_d == CONV;
            pool_q  <= state_d == POOL;
            done_q  <= state_d == COMPLETE;
            err_q   <= state_d == ERROR;
        end
    end
    assign bus.busy_o           = busy_q;
    assign bus.wgt_load_start_o = wls_q;
    assign bus.conv_enable_o    = conv_q;
    assign bus.pool_enable_o    = pool_q;
    assign bus.neuron_idx_o     = idx_q;
    assign bus.cnn_done_o       = done_q;
    assign bus.error_o          = err_q;
endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// tb_cnn_layer_scheduler: directed checks of passes, timeout, abort, spurious
// inputs and reset for a 3-channel, 16-cycle-timeout scheduler.
module tb_cnn_layer_scheduler;
    localparam int NN  = 3;
    localparam int TMO = 16;
    localparam int IW  = 2;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int tests = 0, fails = 0, done_cnt = 0, wls_cnt = 0, overlap = 0;
    cnn_layer_scheduler_if #(.IDX_W(IW)) b ();
    cnn_layer_scheduler #(.NUM_NEURONS(NN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (b.cnn_done_o === 1'b1) done_cnt++;
        if (b.wgt_load_start_o === 1'b1) wls_cnt++;
        if (b.conv_enable_o === 1'b1 && b.pool_enable_o === 1'b1) overlap++;
    end
    initial begin
        #100000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit expired");
    end
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic hold(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    function automatic logic [31:0] outs();
        return 32'({b.busy_o, b.wgt_load_start_o, b.conv_enable_o, b.pool_enable_o, b.cnn_done_o, b.error_o});
    endfunction
    // One full pass from LOAD_W entry, each done returned in the 4th cycle; ends one cycle after NEXT
    task automatic pass(int n);
        chk("wls_entry", 32'(b.wgt_load_start_o), 1);
        chk("idx_entry", 32'(b.neuron_idx_o), n);
        hold(3);
        chk("wls_one_cycle", 32'(b.wgt_load_start_o), 0);
        b.wgt_load_done_i = 1'b1; hold(1); b.wgt_load_done_i = 1'b0;
        chk("conv_rise", 32'({b.conv_enable_o, b.pool_enable_o}), 2);
        hold(3);
        b.conv_done_i = 1'b1; hold(1); b.conv_done_i = 1'b0;
        chk("conv_to_pool", 32'({b.conv_enable_o, b.pool_enable_o}), 1);
        hold(3);
        b.pool_done_i = 1'b1; hold(1); b.pool_done_i = 1'b0;
        chk("next_state", 32'({b.busy_o, b.pool_enable_o}), 2);
        hold(1);
    endtask
    initial begin
        b.start_i = 1'b0; b.abort_i = 1'b0;
        b.wgt_load_done_i = 1'b0; b.conv_done_i = 1'b0; b.pool_done_i = 1'b0;
        hold(2);
        chk("reset_outs", outs(), 0);
        chk("reset_idx", 32'(b.neuron_idx_o), 0);
        reset = 1'b0;
        hold(1);
        chk("idle_outs", outs(), 0);
        // Full three-pass run
        b.start_i = 1'b1; hold(1); b.start_i = 1'b0;
        pass(0);
        pass(1);
        pass(2);
        chk("complete_pulse", 32'({b.cnn_done_o, b.busy_o}), 2);
        chk("complete_idx", 32'(b.neuron_idx_o), 2);
        hold(1);
        chk("after_complete", outs(), 0);
        chk("done_count", 32'(done_cnt), 1);
        chk("wls_count", 32'(wls_cnt), 3);
        // Timeout on neuron 1 conv
        b.start_i = 1'b1; hold(1); b.start_i = 1'b0;
        pass(0);
        hold(3);
        b.wgt_load_done_i = 1'b1; hold(1); b.wgt_load_done_i = 1'b0;
        hold(14);
        chk("pre_timeout", 32'({b.conv_enable_o, b.error_o}), 2);
        hold(1);
        chk("timeout_outs", outs(), 32'h1);
        b.abort_i = 1'b1; hold(1); b.abort_i = 1'b0;
        chk("abort_in_error", 32'(b.error_o), 1);
        b.start_i = 1'b1; hold(1); b.start_i = 1'b0;
        chk("restart_outs", outs(), 32'h30);
        chk("restart_idx", 32'(b.neuron_idx_o), 0);
        // conv_done in the last legal watchdog cycle
        hold(3);
        b.wgt_load_done_i = 1'b1; hold(1); b.wgt_load_done_i = 1'b0;
        hold(14);
        b.conv_done_i = 1'b1; hold(1); b.conv_done_i = 1'b0;
        chk("boundary_pool", outs(), 32'h24);
        hold(3);
        b.pool_done_i = 1'b1; hold(1); b.pool_done_i = 1'b0;
        hold(1);
        chk("idx1_entry", 32'(b.neuron_idx_o), 1);
        // Spurious inputs on neuron 1
        b.conv_done_i = 1'b1; hold(1); b.conv_done_i = 1'b0;
        chk("conv_done_in_load", outs(), 32'h20);
        b.wgt_load_done_i = 1'b1; hold(1); b.wgt_load_done_i = 1'b0;
        b.start_i = 1'b1; hold(1); b.start_i = 1'b0;
        chk("start_in_conv", outs(), 32'h28);
        chk("start_in_conv_idx", 32'(b.neuron_idx_o), 1);
        b.pool_done_i = 1'b1; hold(1); b.pool_done_i = 1'b0;
        chk("pool_done_in_conv", outs(), 32'h28);
        b.conv_done_i = 1'b1; hold(1); b.conv_done_i = 1'b0;
        b.pool_done_i = 1'b1; hold(1); b.pool_done_i = 1'b0;
        hold(1);
        chk("idx2_entry", 32'({b.wgt_load_start_o, b.neuron_idx_o}), 6);
        // Abort together with pool_done on neuron 2
        b.wgt_load_done_i = 1'b1; hold(1); b.wgt_load_done_i = 1'b0;
        b.conv_done_i = 1'b1; hold(1); b.conv_done_i = 1'b0;
        chk("pool_before_abort", 32'(b.pool_enable_o), 1);
        b.abort_i = 1'b1; b.pool_done_i = 1'b1; hold(1);
        b.abort_i = 1'b0; b.pool_done_i = 1'b0;
        chk("abort_outs", outs(), 0);
        hold(3);
        chk("abort_no_done", 32'(done_cnt), 1);
        chk("abort_stays_idle", outs(), 0);
        // Synchronous reset mid-CONV of neuron 1
        b.start_i = 1'b1; hold(1); b.start_i = 1'b0;
        pass(0);
        b.wgt_load_done_i = 1'b1; hold(1); b.wgt_load_done_i = 1'b0;
        chk("pre_reset", 32'({b.conv_enable_o, b.neuron_idx_o}), 5);
        reset = 1'b1; hold(1);
        chk("mid_reset_outs", outs(), 0);
        chk("mid_reset_idx", 32'(b.neuron_idx_o), 0);
        b.start_i = 1'b1; hold(1);
        chk("reset_blocks_start", outs(), 0);
        reset = 1'b0; b.start_i = 1'b0; hold(1);
        chk("post_reset_idle", outs(), 0);
        chk("no_overlap", 32'(overlap), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
